// File: rtl/bcd_seg_scanner.sv
// Three-digit common-anode 7-segment scanner for BCD input.
// A loaded value is held as pending and swapped into the display only at a frame boundary.
module bcd_seg_scanner #(
  parameter int REFRESH_DIV = 16384,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       pending,
  output logic       frame_done
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

  // Handshake: load is a single-cycle strobe with no ready; the block always accepts it.
  logic [DW-1:0] r_div_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_disp_h, r_disp_t, r_disp_o;
  logic [3:0]    r_pend_h, r_pend_t, r_pend_o;
  logic          r_pending;
  logic          r_frame_done;
  logic [6:0]    r_seg;
  logic [2:0]    r_an;

  logic          w_div_wrap;
  logic          w_frame_end;
  logic [3:0]    w_digit;
  logic          w_digit_blank;
  logic [6:0]    w_seg_next;
  logic [2:0]    w_an_next;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h3F;
    endcase
  endfunction

  assign w_div_wrap  = (r_div_cnt == DIV_LAST);
  assign w_frame_end = w_div_wrap && (r_idx == 2'd2);

  // A non-zero (including invalid) hundreds digit ends zero suppression for tens.
  always_comb begin
    w_digit       = r_disp_o;
    w_digit_blank = 1'b0;
    case (r_idx)
      2'd1: begin
        w_digit       = r_disp_t;
        w_digit_blank = LZ_BLANK && (r_disp_h == 4'd0) && (r_disp_t == 4'd0);
      end
      2'd2: begin
        w_digit       = r_disp_h;
        w_digit_blank = LZ_BLANK && (r_disp_h == 4'd0);
      end
      default: begin
        w_digit       = r_disp_o;
        w_digit_blank = 1'b0;
      end
    endcase
    w_seg_next = w_digit_blank ? 7'h7F : seg_code(w_digit);
    w_an_next  = (w_digit_blank || blank) ? 3'b111 : ~(3'b001 << r_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_idx     <= 2'd0;
    end else if (w_div_wrap) begin
      r_div_cnt <= '0;
      r_idx     <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_div_cnt <= r_div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_h  <= 4'd0;
      r_pend_t  <= 4'd0;
      r_pend_o  <= 4'd0;
      r_pending <= 1'b0;
      r_disp_h  <= 4'd0;
      r_disp_t  <= 4'd0;
      r_disp_o  <= 4'd0;
    end else begin
      if (load) begin
        r_pend_h <= hundreds;
        r_pend_t <= tens;
        r_pend_o <= ones;
      end
      if (w_frame_end) begin
        // A load on the boundary bypasses the pending buffer.
        if (load) begin
          r_disp_h <= hundreds;
          r_disp_t <= tens;
          r_disp_o <= ones;
        end else if (r_pending) begin
          r_disp_h <= r_pend_h;
          r_disp_t <= r_pend_t;
          r_disp_o <= r_pend_o;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg        <= 7'h7F;
      r_an         <= 3'b111;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_next;
      r_an         <= w_an_next;
      r_frame_done <= w_frame_end;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed bench for bcd_seg_scanner with REFRESH_DIV=4; one instance per LZ_BLANK setting.
module tb_bcd_seg_scanner;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] hundreds, tens, ones;
  logic       blank;
  logic [6:0] seg, seg0;
  logic [2:0] an, an0;
  logic       pending, pending0;
  logic       frame_done, frame_done0;

  int n_cmp;
  int n_err;
  int cyc;

  bcd_seg_scanner #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .reset(reset), .load(load), .hundreds(hundreds), .tens(tens), .ones(ones),
    .blank(blank), .seg(seg), .an(an), .pending(pending), .frame_done(frame_done)
  );

  bcd_seg_scanner #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) dut0 (
    .clk(clk), .reset(reset), .load(load), .hundreds(hundreds), .tens(tens), .ones(ones),
    .blank(blank), .seg(seg0), .an(an0), .pending(pending0), .frame_done(frame_done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    hundreds = h;
    tens     = t;
    ones     = o;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Returns at the negedge where frame_done is high; cycles = negedges waited.
  task automatic wait_fd(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!frame_done && cycles < 100);
    if (!frame_done) check_eq("frame_done_timeout", 32'd0, 32'd1);
  endtask

  // Called at a frame_done negedge; samples the first cycle of each digit slot.
  task automatic check_frame(input string tag, input bit lz0,
                             input logic [6:0] so, input logic [2:0] ao,
                             input logic [6:0] st, input logic [2:0] at,
                             input logic [6:0] sh, input logic [2:0] ah);
    @(negedge clk);
    check_eq({tag, "_fd_width"}, frame_done, 1'b0);
    check_eq({tag, "_ones_seg"}, lz0 ? seg0 : seg, so);
    check_eq({tag, "_ones_an"},  lz0 ? an0  : an,  ao);
    repeat (4) @(negedge clk);
    check_eq({tag, "_tens_seg"}, lz0 ? seg0 : seg, st);
    check_eq({tag, "_tens_an"},  lz0 ? an0  : an,  at);
    repeat (4) @(negedge clk);
    check_eq({tag, "_hund_seg"}, lz0 ? seg0 : seg, sh);
    check_eq({tag, "_hund_an"},  lz0 ? an0  : an,  ah);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    load     = 1'b0;
    hundreds = 4'd0;
    tens     = 4'd0;
    ones     = 4'd0;
    blank    = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_seg", seg, 7'h7F);
    check_eq("rst_an", an, 3'b111);
    check_eq("rst_pending", pending, 1'b0);
    check_eq("rst_fd", frame_done, 1'b0);
    reset = 1'b0;

    // 1: zero display with leading-zero blanking, frame period
    check_frame("t1", 1'b0, 7'h40, 3'b110, 7'h7F, 3'b111, 7'h7F, 3'b111);
    wait_fd(cyc);
    check_eq("t1_first_frame_len", 9 + cyc, 12);
    wait_fd(cyc);
    check_eq("t1_frame_len", cyc, 12);
    check_frame("t1_lz0", 1'b1, 7'h40, 3'b110, 7'h40, 3'b101, 7'h40, 3'b011);

    // 2: mid-frame load held until frame end
    wait_fd(cyc);
    @(negedge clk);
    do_load(4'd2, 4'd5, 4'd5);
    check_eq("t2_pending_set", pending, 1'b1);
    check_eq("t2_old_ones_seg", seg, 7'h40);
    wait_fd(cyc);
    check_eq("t2_pending_clr", pending, 1'b0);
    check_frame("t2", 1'b0, 7'h12, 3'b110, 7'h12, 3'b101, 7'h24, 3'b011);

    // 3: last load in a frame wins
    wait_fd(cyc);
    @(negedge clk);
    do_load(4'd0, 4'd0, 4'd7);
    @(negedge clk);
    do_load(4'd0, 4'd4, 4'd2);
    check_eq("t3_pending", pending, 1'b1);
    wait_fd(cyc);
    check_frame("t3", 1'b0, 7'h24, 3'b110, 7'h19, 3'b101, 7'h7F, 3'b111);

    // 4: load coincident with frame end commits directly
    wait_fd(cyc);
    repeat (11) @(negedge clk);
    do_load(4'd3, 4'd1, 4'd8);
    check_eq("t4_fd", frame_done, 1'b1);
    check_eq("t4_pending_0", pending, 1'b0);
    check_frame("t4", 1'b0, 7'h00, 3'b110, 7'h79, 3'b101, 7'h30, 3'b011);
    check_eq("t4_pending_1", pending, 1'b0);

    // 5: LZ_BLANK=0 zeros, invalid digits
    wait_fd(cyc);
    do_load(4'd0, 4'd0, 4'd0);
    wait_fd(cyc);
    check_frame("t5_zero_lz0", 1'b1, 7'h40, 3'b110, 7'h40, 3'b101, 7'h40, 3'b011);
    wait_fd(cyc);
    do_load(4'hC, 4'd0, 4'd5);
    wait_fd(cyc);
    check_frame("t5_dash_lz0", 1'b1, 7'h12, 3'b110, 7'h40, 3'b101, 7'h3F, 3'b011);
    wait_fd(cyc);
    check_frame("t5_dash_lz1", 1'b0, 7'h12, 3'b110, 7'h40, 3'b101, 7'h3F, 3'b011);
    wait_fd(cyc);
    do_load(4'd0, 4'hA, 4'd3);
    wait_fd(cyc);
    check_frame("t5_tens_dash", 1'b0, 7'h30, 3'b110, 7'h3F, 3'b101, 7'h7F, 3'b111);

    // 6: blank input, then asynchronous mid-frame reset
    wait_fd(cyc);
    blank = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("t6_blank_an_%0d", i), an, 3'b111);
    end
    blank = 1'b0;
    wait_fd(cyc);
    check_eq("t6_frame_len", 5 + cyc, 12);
    @(negedge clk);
    check_eq("t6_unblank_an", an, 3'b110);
    check_eq("t6_unblank_seg", seg, 7'h30);
    do_load(4'd1, 4'd2, 4'd3);
    check_eq("t6_pending_pre", pending, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_arst_seg", seg, 7'h7F);
    check_eq("t6_arst_an", an, 3'b111);
    check_eq("t6_arst_pending", pending, 1'b0);
    check_eq("t6_arst_fd", frame_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6_post_seg", seg, 7'h40);
    check_eq("t6_post_an", an, 3'b110);
    check_eq("t6_post_pending", pending, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
